// File: rtl/hazard_unit_p.sv
// hazard_unit_p: D-stage stall/bubble control and operand forwarding selects for a 5-stage MIPS pipeline.
// Tracks shadow {a3, tnew} for E/M/W and ages tnew every cycle.
// Optional feature macro HAZARD_MD_EN adds a multiply/divide busy tracker that stalls HI/LO-class instructions.
// Ports: clk, reset (sync, active-high); rs_D/rt_D, tuse_*, use_* describe D-stage sources;
// a3_D/tnew_D describe the D-stage destination; md_start_D/md_div_D/md_use_D describe MD-class instructions;
// en_pc/en_d/clr_e are the stall controls; fwd_rs_D/fwd_rt_D select 0 GRF, 1 E, 2 M, 3 W; md_busy flags the MD unit.
module hazard_unit_p #(
  parameter int TW = 2,
  parameter int RW = 5,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC = 10,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] rs_D,
  input  logic [RW-1:0] rt_D,
  input  logic [TW-1:0] tuse_rs_D,
  input  logic [TW-1:0] tuse_rt_D,
  input  logic          use_rs_D,
  input  logic          use_rt_D,
  input  logic [RW-1:0] a3_D,
  input  logic [TW-1:0] tnew_D,
  input  logic          md_start_D,
  input  logic          md_div_D,
  input  logic          md_use_D,
  output logic          en_pc,
  output logic          en_d,
  output logic          clr_e,
  output logic [1:0]    fwd_rs_D,
  output logic [1:0]    fwd_rt_D,
  output logic          md_busy
);
  logic [RW-1:0] a3_e, a3_m, a3_w;
  logic [TW-1:0] tnew_e, tnew_m, tnew_w;
  logic hz_rs, hz_rt, md_stall, stall;
  // The nearest stage holding the register decides; a match in E hides any older M copy.
  assign hz_rs = use_rs_D && rs_D != '0 &&
                 (rs_D == a3_e ? tnew_e > tuse_rs_D : rs_D == a3_m && tnew_m > tuse_rs_D);
  assign hz_rt = use_rt_D && rt_D != '0 &&
                 (rt_D == a3_e ? tnew_e > tuse_rt_D : rt_D == a3_m && tnew_m > tuse_rt_D);
  assign fwd_rs_D = rs_D == '0 ? 2'd0 :
                    (rs_D == a3_e && tnew_e == '0) ? 2'd1 :
                    (rs_D == a3_m && tnew_m == '0) ? 2'd2 :
                    (rs_D == a3_w && tnew_w == '0) ? 2'd3 : 2'd0;
  assign fwd_rt_D = rt_D == '0 ? 2'd0 :
                    (rt_D == a3_e && tnew_e == '0) ? 2'd1 :
                    (rt_D == a3_m && tnew_m == '0) ? 2'd2 :
                    (rt_D == a3_w && tnew_w == '0) ? 2'd3 : 2'd0;
  assign stall = hz_rs || hz_rt || md_stall;
  assign en_pc = !stall;
  assign en_d  = !stall;
  assign clr_e = stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      a3_e   <= '0;
      tnew_e <= '0;
      a3_m   <= '0;
      tnew_m <= '0;
      a3_w   <= '0;
      tnew_w <= '0;
    end else begin
      a3_e   <= stall ? '0 : a3_D;
      tnew_e <= stall ? '0 : tnew_D;
      a3_m   <= a3_e;
      tnew_m <= tnew_e == '0 ? '0 : tnew_e - TW'(1);
      a3_w   <= a3_m;
      tnew_w <= tnew_m == '0 ? '0 : tnew_m - TW'(1);
    end
  end
`ifdef HAZARD_MD_EN
  logic md_start_e, md_div_e;
  logic [CW-1:0] cnt;
  // A start sitting in E already counts as busy, before the counter is loaded.
  assign md_busy  = md_start_e || cnt != '0;
  assign md_stall = md_use_D && md_busy;
  always_ff @(posedge clk) begin
    if (reset) begin
      md_start_e <= 1'b0;
      md_div_e   <= 1'b0;
      cnt        <= '0;
    end else begin
      md_start_e <= stall ? 1'b0 : md_start_D;
      md_div_e   <= stall ? 1'b0 : md_div_D;
      cnt        <= md_start_e ? (md_div_e ? CW'(DIV_CYC) : CW'(MULT_CYC)) :
                    cnt != '0 ? cnt - CW'(1) : cnt;
    end
  end
`else
  logic unused_md;
  assign unused_md = ^{md_start_D, md_div_D, md_use_D, CW'(MULT_CYC), CW'(DIV_CYC)};
  assign md_busy  = 1'b0;
  assign md_stall = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_unit_p.sv
// tb_hazard_unit_p: self-checking bench for hazard_unit_p (directed table, MD sequences, randomized model compare).
module tb_hazard_unit_p;
  localparam int MULT = 5;
  localparam int DIV = 10;
`ifdef HAZARD_MD_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] rs_D, rt_D, a3_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
  logic use_rs_D, use_rt_D, md_start_D, md_div_D, md_use_D;
  logic en_pc, en_d, clr_e, md_busy;
  logic [1:0] fwd_rs_D, fwd_rt_D;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hazard_unit_p #(.TW(2), .RW(5), .MULT_CYC(MULT), .DIV_CYC(DIV), .CW(4)) dut (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .use_rs_D(use_rs_D), .use_rt_D(use_rt_D), .a3_D(a3_D), .tnew_D(tnew_D), .md_start_D(md_start_D),
    .md_div_D(md_div_D), .md_use_D(md_use_D), .en_pc(en_pc), .en_d(en_d), .clr_e(clr_e),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .md_busy(md_busy)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic drv(input int rs, input int rt, input int tur, input int tut, input int ur, input int ut,
                     input int a3, input int tn, input int ms, input int mdv, input int mu);
    rs_D = 5'(rs); rt_D = 5'(rt); tuse_rs_D = 2'(tur); tuse_rt_D = 2'(tut);
    use_rs_D = 1'(ur); use_rt_D = 1'(ut); a3_D = 5'(a3); tnew_D = 2'(tn);
    md_start_D = 1'(ms); md_div_D = 1'(mdv); md_use_D = 1'(mu);
  endtask
  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  // Reference model: each in-flight result remembers the absolute cycle it becomes ready.
  int m_a3[3];
  int m_rdy[3];
  int m_end;
  int now;
  function automatic int tn(int i);
    return m_rdy[i] > now ? m_rdy[i] - now : 0;
  endfunction
  function automatic int m_fwd(int s);
    if (s == 0) return 0;
    for (int i = 0; i < 3; i++) if (m_a3[i] == s && tn(i) == 0) return i + 1;
    return 0;
  endfunction
  function automatic bit m_hz(bit u, int s, int tu);
    if (!u || s == 0) return 1'b0;
    for (int i = 0; i < 2; i++) if (m_a3[i] == s) return tn(i) > tu;
    return 1'b0;
  endfunction
  function automatic bit m_busy();
    return MD && now <= m_end;
  endfunction
  function automatic void m_clear();
    for (int i = 0; i < 3; i++) begin
      m_a3[i] = 0;
      m_rdy[i] = 0;
    end
    m_end = -1;
  endfunction
  function automatic void m_step(bit stall);
    if (reset) m_clear();
    else begin
      for (int i = 2; i > 0; i--) begin
        m_a3[i] = m_a3[i-1];
        m_rdy[i] = m_rdy[i-1];
      end
      m_a3[0] = stall ? 0 : int'(a3_D);
      m_rdy[0] = stall ? 0 : now + 1 + int'(tnew_D);
      if (!stall && md_start_D) m_end = now + 1 + (md_div_D ? DIV : MULT);
    end
    now++;
  endfunction
  typedef struct {
    int rs, rt, tur, tut, ur, ut, a3, tn;
    int stall, frs, frt;
  } vec_t;
  vec_t tbl[11];
  task automatic md_seq(input bit dv, input int expn, input string nm);
    int n, b;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, int'(dv), 1);
    #1 chk({nm, "_issue_en_pc"}, en_pc, 1);
    @(posedge clk); #1;
    drv(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1);
    n = 0;
    b = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (md_busy) b++;
      if (en_pc) break;
      n++;
      @(posedge clk); #1;
    end
    chk({nm, "_stall_cycles"}, n, MD ? expn : 0);
    chk({nm, "_busy_cycles"}, b, MD ? expn : 0);
    nop();
    @(posedge clk); #1;
  endtask
  bit es;
  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 8, 2, 0, 0, 0};
    tbl[1]  = '{8, 0, 1, 0, 1, 0, 9, 1, 1, 0, 0};
    tbl[2]  = '{8, 0, 1, 0, 1, 0, 9, 1, 0, -1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 8, 2, 0, 0, 0};
    tbl[4]  = '{8, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    tbl[5]  = '{8, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    tbl[6]  = '{8, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 31, 0, 0, 0, 0};
    tbl[8]  = '{31, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0};
    tbl[10] = '{0, 31, 0, 0, 1, 1, 0, 0, 0, 0, 3};
    reset = 1'b1;
    drv(8, 0, 0, 0, 1, 0, 8, 2, 0, 0, 0);
    @(posedge clk); #1;
    chk("rst_en_pc", en_pc, 1);
    chk("rst_clr_e", clr_e, 0);
    chk("rst_fwd_rs", fwd_rs_D, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post_rst_en_pc", en_pc, 1);
    chk("post_rst_en_d", en_d, 1);
    chk("post_rst_clr_e", clr_e, 0);
    chk("post_rst_fwd_rs", fwd_rs_D, 0);
    chk("post_rst_busy", md_busy, 0);
    nop();
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) begin
      drv(tbl[i].rs, tbl[i].rt, tbl[i].tur, tbl[i].tut, tbl[i].ur, tbl[i].ut, tbl[i].a3, tbl[i].tn, 0, 0, 0);
      #1;
      chk($sformatf("vec%0d_en_pc", i), en_pc, tbl[i].stall == 0);
      chk($sformatf("vec%0d_en_d", i), en_d, tbl[i].stall == 0);
      chk($sformatf("vec%0d_clr_e", i), clr_e, tbl[i].stall != 0);
      if (tbl[i].frs >= 0) chk($sformatf("vec%0d_fwd_rs", i), fwd_rs_D, tbl[i].frs);
      chk($sformatf("vec%0d_fwd_rt", i), fwd_rt_D, tbl[i].frt);
      chk($sformatf("vec%0d_busy", i), md_busy, 0);
      @(posedge clk); #1;
    end
    nop();
    repeat (3) @(posedge clk);
    #1;
    md_seq(1'b1, DIV + 1, "div_mflo");
    md_seq(1'b0, MULT + 1, "mult_mflo");
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    @(posedge clk); #1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1 chk("mid_busy_stall", en_pc, MD ? 0 : 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_busy_en_pc", en_pc, 1);
    chk("rst_mid_busy_busy", md_busy, 0);
    reset = 1'b1;
    nop();
    @(posedge clk); #1;
    reset = 1'b0;
    m_clear();
    now = 0;
    for (int k = 0; k < 3000; k++) begin
      int ms;
      ms = ($urandom % 12) == 0 ? 1 : 0;
      drv($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
          ms, $urandom_range(0, 1), (ms == 1 || ($urandom % 5) == 0) ? 1 : 0);
      reset = ($urandom % 80) == 0;
      #1;
      es = m_hz(use_rs_D, int'(rs_D), int'(tuse_rs_D)) || m_hz(use_rt_D, int'(rt_D), int'(tuse_rt_D)) ||
           (md_use_D && m_busy());
      chk("rnd_en_pc", en_pc, !es);
      chk("rnd_en_d", en_d, !es);
      chk("rnd_clr_e", clr_e, es);
      chk("rnd_fwd_rs", fwd_rs_D, m_fwd(int'(rs_D)));
      chk("rnd_fwd_rt", fwd_rt_D, m_fwd(int'(rt_D)));
      chk("rnd_busy", md_busy, m_busy());
      @(posedge clk);
      m_step(es);
      #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
